// File: rtl/fifo_drain.sv
// Drains an upstream FIFO (registered flags, 1-cycle read latency) into a 2-entry skid buffer.
// Optional word counter output o_word_cnt when FIFO_DRAIN_CNT_EN is defined.
module fifo_drain #(
  parameter int DATA_WIDTH  = 128,
  parameter bit BURST_START = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_fifo_empty,
  input  logic                  i_fifo_alm_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rddata,
  output logic                  o_fifo_rden,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic                  o_busy
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [31:0]           o_word_cnt
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic                  inflight_q;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic                  pop, cap, start, credit_ok, pace_ok, rden;

  assign pop = (occ_q != 2'd0) && i_ready;
  assign cap = inflight_q;

  // A read issued now lands next cycle; it must find a free slot after this cycle's pop.
  assign credit_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
  // Flags lag by a cycle, so only read back-to-back while well clear of empty.
  assign pace_ok   = !inflight_q || !i_fifo_alm_empty;
  assign rden      = (state_q == S_RUN) && !i_fifo_empty && credit_ok && pace_ok;
  assign o_fifo_rden = rden && !rst;

  generate
    if (BURST_START) begin : g_burst
      assign start = i_flush || (!i_fifo_alm_empty && !i_fifo_empty);
    end else begin : g_eager
      assign start = i_flush || !i_fifo_empty;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (i_fifo_empty && !inflight_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // buf0 is always the oldest word; buf1 only holds data when occ == 2.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({cap, pop})
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = i_fifo_rddata;
        else               buf1_d = i_fifo_rddata;
        occ_d = occ_q + 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = i_fifo_rddata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = i_fifo_rddata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rden;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign o_valid = (occ_q != 2'd0);
  assign o_data  = buf0_q;
  assign o_busy  = (state_q != S_IDLE) || inflight_q || (occ_q != 2'd0);

`ifdef FIFO_DRAIN_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)      cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 32'd1;
  end

  assign o_word_cnt = cnt_q;
`endif

endmodule
